// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, execute update and perf-counter signals of the direction predictor
interface branch_predictor_if;
   logic        req_valid;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic        resp_taken;
   logic        resp_hit;
   logic [31:0] resp_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic        upd_pred_taken;
   logic [31:0] upd_target;
   logic        flush;
   logic [31:0] mispredict_cnt;
   modport slave (
      input  req_valid, req_pc, upd_valid, upd_pc, upd_taken, upd_pred_taken, upd_target, flush,
      output resp_valid, resp_taken, resp_hit, resp_target, mispredict_cnt
   );
   modport master (
      output req_valid, req_pc, upd_valid, upd_pc, upd_taken, upd_pred_taken, upd_target, flush,
      input  resp_valid, resp_taken, resp_hit, resp_target, mispredict_cnt
   );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating counter direction predictor with registered lookup and mispredict counter.
// Define BP_BTB_EN to add a direct-mapped tagged BTB that gates the taken prediction.
module branch_predictor #(
   parameter int INDEX_BITS = 6
) (
   input logic         clock,
   input logic         reset_n,
   branch_predictor_if.slave bus
);
   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;
   logic [1:0] ctr [ENTRIES];
   logic [INDEX_BITS-1:0] req_idx, upd_idx;
   logic [1:0] upd_old, upd_new, req_ctr;
   logic mispredict;
   logic [31:0] mp_cnt;
   logic look_taken, look_hit;
   logic [31:0] look_target;
   assign req_idx = bus.req_pc[INDEX_BITS+1:2];
   assign upd_idx = bus.upd_pc[INDEX_BITS+1:2];
   assign upd_old = ctr[upd_idx];
   assign upd_new = bus.upd_taken ? (upd_old == 2'd3 ? 2'd3 : upd_old + 2'd1)
                                  : (upd_old == 2'd0 ? 2'd0 : upd_old - 2'd1);
   // same-cycle update to the looked-up entry is forwarded so fetch sees the trained value
   assign req_ctr = (bus.upd_valid && upd_idx == req_idx) ? upd_new : ctr[req_idx];
   assign mispredict = bus.upd_valid && (bus.upd_taken != bus.upd_pred_taken);
   assign bus.mispredict_cnt = mp_cnt;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
      end else if (bus.upd_valid) begin
         ctr[upd_idx] <= upd_new;
      end
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) mp_cnt <= '0;
      else mp_cnt <= (mispredict && mp_cnt != '1) ? mp_cnt + 32'd1 : mp_cnt;
   end
`ifdef BP_BTB_EN
   logic btb_valid [ENTRIES];
   logic [TAG_BITS-1:0] btb_tag [ENTRIES];
   logic [31:0] btb_target [ENTRIES];
   logic btb_wr, btb_byp, l_valid;
   logic [TAG_BITS-1:0] upd_tag, req_tag, l_tag;
   logic [31:0] l_target;
   logic unused_bits;
   assign unused_bits = ^{bus.req_pc[1:0], bus.upd_pc[1:0]};
   assign upd_tag = bus.upd_pc[31:INDEX_BITS+2];
   assign req_tag = bus.req_pc[31:INDEX_BITS+2];
   assign btb_wr = bus.upd_valid && bus.upd_taken;
   assign btb_byp = btb_wr && upd_idx == req_idx;
   assign l_valid = btb_byp || btb_valid[req_idx];
   assign l_tag = btb_byp ? upd_tag : btb_tag[req_idx];
   assign l_target = btb_byp ? bus.upd_target : btb_target[req_idx];
   assign look_hit = l_valid && l_tag == req_tag;
   assign look_target = look_hit ? l_target : 32'd0;
   assign look_taken = req_ctr[1] && look_hit;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) btb_valid[i] <= 1'b0;
      end else if (btb_wr) begin
         btb_valid[upd_idx] <= 1'b1;
      end
   end
   // tag/target need no reset: they are only observed through a set valid bit
   always_ff @(posedge clock) begin
      if (btb_wr) begin
         btb_tag[upd_idx] <= upd_tag;
         btb_target[upd_idx] <= bus.upd_target;
      end
   end
`else
   logic unused_bits;
   assign unused_bits = ^{bus.req_pc[1:0], bus.req_pc[31:INDEX_BITS+2], bus.upd_pc[1:0],
                          bus.upd_pc[31:INDEX_BITS+2], bus.upd_target};
   assign look_hit = 1'b0;
   assign look_target = 32'd0;
   assign look_taken = req_ctr[1];
`endif
   // flushed lookups are squashed entirely, so the held response data stays untouched
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.resp_valid <= 1'b0;
         bus.resp_taken <= 1'b0;
         bus.resp_hit <= 1'b0;
         bus.resp_target <= '0;
      end else begin
         bus.resp_valid <= bus.req_valid && !bus.flush;
         if (bus.req_valid && !bus.flush) begin
            bus.resp_taken <= look_taken;
            bus.resp_hit <= look_hit;
            bus.resp_target <= look_target;
         end
      end
   end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side direction predictor; the other end of the execute-stage branch comparator.
- Fetch issues a lookup per PC and receives a registered taken/not-taken prediction one cycle later.
- Execute feeds back each resolved outcome (branch_taken) to train a table of 2-bit saturating counters.
- Also counts mispredictions for performance monitoring.

Parameters:
INDEX_BITS, 6, log2 of table entries (64); legal 2..10; index = pc[INDEX_BITS+1:2]

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  fetch lookup request
req_pc  input  32  PC of fetched instruction
resp_valid  output  1  prediction valid, one cycle after req
resp_taken  output  1  predicted taken
resp_hit  output  1  BTB tag hit (BP_BTB_EN only, else 0)
resp_target  output  32  predicted target (BP_BTB_EN only, else 0)
upd_valid  input  1  resolved conditional branch from execute
upd_pc  input  32  PC of resolved branch
upd_taken  input  1  actual outcome from branch comparator
upd_pred_taken  input  1  prediction carried down the pipe with this branch
upd_target  input  32  resolved branch target
flush  input  1  squash in-flight lookup
mispredict_cnt  output  32  saturating misprediction count

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream):
  - all counters = 2'b01 (weakly not-taken)
  - resp_valid = 0, resp_taken = 0, resp_hit = 0, resp_target = 0, mispredict_cnt = 0
  - BTB valid bits = 0
  - reset mid-operation discards any pending response.
- Lookup:
  - req_valid in cycle N -> resp_valid = 1 in cycle N+1 with resp_* registered.
  - No req_valid in N -> resp_valid = 0 in N+1; resp_taken/hit/target hold their last values.
  - One request per cycle, no backpressure.
- Flush:
  - flush in cycle N forces resp_valid = 0 in N+1, even if req_valid in N.
  - flush does not block an update in the same cycle.
- Counter update on upd_valid:
  - upd_taken=1 -> counter+1, saturates at 3.
  - upd_taken=0 -> counter-1, saturates at 0.
  - Prediction = counter[1].
- Same-cycle req and upd to the same index:
  - the response reflects the post-update counter (bypass).
  - A different index sees the current value.
- Mispredict counter:
  - increments when upd_valid && (upd_taken != upd_pred_taken).
  - holds at 32'hFFFF_FFFF, never wraps.
- Aliasing: PCs sharing an index share a counter; no tag check without BTB.
- PC bits [1:0] are ignored.

Optional Feature:
Macro BP_BTB_EN.
- Defined:
  - Adds a direct-mapped BTB per index holding valid, tag = pc[31:INDEX_BITS+2], and target.
  - Entry written on upd_valid && upd_taken (tag, target, valid=1); not-taken updates leave the BTB unchanged.
  - resp_hit = valid && tag match.
  - resp_target = stored target when hit, else 0.
  - resp_taken = counter[1] && resp_hit.
  - Same-cycle same-index bypass also applies to BTB contents.
- Not defined:
  - No BTB storage.
  - resp_hit = 0, resp_target = 0, resp_taken = counter[1].

Test Plan:
- Reset, then req_pc=0x100 -> next cycle resp_valid=1, resp_taken=0; mispredict_cnt=0.
- Two taken updates to pc=0x100 (01->10->11), then lookup 0x100 -> resp_taken=1.
- Three not-taken updates from 11 -> counter 00; a fourth stays at 00 -> lookup resp_taken=0.
- Aliasing: update taken on 0x104 twice, lookup 0x204 (INDEX_BITS=6, same index) -> resp_taken=1.
- Same cycle: upd_valid taken pc=0x100 from 01, and req 0x100 -> resp_taken=1 (bypass).
- Flush with req_valid -> resp_valid=0 next cycle.
- Five updates with upd_taken!=upd_pred_taken plus two matching -> mispredict_cnt=5.
- Force counter to 0xFFFF_FFFF, one more mispredict -> stays 0xFFFF_FFFF.
- BP_BTB_EN: taken update pc=0x100 target=0x200 -> lookup 0x100 gives hit=1, target=0x200, taken=1.
- BP_BTB_EN: lookup 0x200 (same index, different tag) -> hit=0, taken=0.
- Assert reset_n mid-stream after training -> all counters back to 01, resp_valid=0 immediately.
